// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game sequencer.
// Optional pause support is enabled by defining SNAKE_PAUSE_EN.
package snake_pkg;

    typedef enum logic [1:0] {
        GS_INIT  = 2'd0,
        GS_RUN   = 2'd1,
        GS_STOP  = 2'd2,
        GS_PAUSE = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        EX_UPDATE     = 3'd0,
        EX_CHECK      = 3'd1,
        EX_TICK       = 3'd2,
        EX_WAIT_LOGIC = 3'd3,
        EX_DISPLAY    = 3'd4
    } exec_t;

    // Button vector is {RIGHT, LEFT, DOWN, UP}.
    localparam logic [3:0] BTN_UP    = 4'b0001;
    localparam logic [3:0] BTN_DOWN  = 4'b0010;
    localparam logic [3:0] BTN_LEFT  = 4'b0100;
    localparam logic [3:0] BTN_RIGHT = 4'b1000;

    // UP/DOWN and LEFT/RIGHT share bit 1 and differ only in bit 0.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    function automatic logic is_onehot(input logic [3:0] b);
        return (b != 4'b0000) && ((b & (b - 4'b0001)) == 4'b0000);
    endfunction

    function automatic dir_t btn_to_dir(input logic [3:0] b);
        dir_t d;
        case (b)
            BTN_DOWN:  d = DIR_DOWN;
            BTN_LEFT:  d = DIR_LEFT;
            BTN_RIGHT: d = DIR_RIGHT;
            default:   d = DIR_UP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/snake_turn_queue.sv
// Turn queue: button edge detect, direction filtering and a small FIFO.
module snake_turn_queue
    import snake_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       restart,
    input  logic [3:0] buttons,
    input  dir_t       current,
    input  logic       pop,
    output logic       press,
    output dir_t       head,
    output logic       empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [3:0]    prev_q;
    dir_t          mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;
    dir_t          tail_q;
    dir_t          new_dir, ref_dir;
    logic          full, push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem_q[rd_q];

    // Accept a fresh one-hot press that changes course and fits in the queue.
    always_comb begin
        press   = is_onehot(buttons) && ((buttons & ~prev_q) != 4'b0000);
        new_dir = btn_to_dir(buttons);
        ref_dir = empty ? current : tail_q;
        push    = press && !full && (new_dir != ref_dir) && !is_reverse(new_dir, ref_dir);
        do_pop  = pop && !empty;
    end

    // FIFO storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (restart) begin
            prev_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            tail_q  <= DIR_RIGHT;
        end else begin
            prev_q <= buttons;
            if (push) begin
                mem_q[wr_q] <= new_dir;
                tail_q      <= new_dir;
                wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/snake_sequencer.sv
// Snake game sequencer: game state, direction, datapath handshake and LED scan.
// Define SNAKE_PAUSE_EN to enable the RUN<->PAUSE toggle on pause_in.
module snake_sequencer
    import snake_pkg::*;
#(
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned DISPLAY_FRAMES = 2,
    parameter int unsigned ROW_HOLD       = 4,
    parameter int unsigned DIR_QDEPTH     = 2,
    parameter int unsigned LOGIC_TIMEOUT  = 255
) (
    input  logic                 clka,
    input  logic                 restart,
    input  logic [3:0]           direction_in,
    input  logic                 logic_done,
    input  logic                 game_end,
    input  logic                 pause_in,
    input  logic [ROWS*COLS-1:0] led_flat,
    output logic [1:0]           game_state,
    output logic [1:0]           direction,
    output logic [2:0]           exec_state,
    output logic                 logic_tick,
    output logic                 no_update,
    output logic                 timeout_err,
    output logic [ROWS-1:0]      row_cathode,
    output logic [COLS-1:0]      column_anode
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned HW = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
    localparam int unsigned FW = (DISPLAY_FRAMES > 1) ? $clog2(DISPLAY_FRAMES) : 1;
    localparam int unsigned TW = (LOGIC_TIMEOUT > 1) ? $clog2(LOGIC_TIMEOUT) : 1;

    exec_t         exec_q, exec_n;
    game_state_t   gs_q, gs_n;
    dir_t          dir_q, dir_n;
    logic          tick_q, tick_n, noupd_q, noupd_n, terr_q, terr_n;
    logic [ROWS-1:0] cath_q, cath_n;
    logic [COLS-1:0] anode_q, anode_n;
    logic [RW-1:0] row_q, row_n;
    logic [HW-1:0] hold_q, hold_n;
    logic [FW-1:0] frame_q, frame_n;
    logic [TW-1:0] tout_q, tout_n;
    logic          gend_q, gend_n, start_q, start_n, pause_q, pause_n, pause_prev_q;
    logic          pop, press, q_empty, skip_tick;
    dir_t          q_head;

    snake_turn_queue #(.DEPTH(DIR_QDEPTH)) u_turn_queue (
        .clk     (clka),
        .restart (restart),
        .buttons (direction_in),
        .current (dir_q),
        .pop     (pop),
        .press   (press),
        .head    (q_head),
        .empty   (q_empty)
    );

    assign game_state   = gs_q;
    assign direction    = dir_q;
    assign exec_state   = exec_q;
    assign logic_tick   = tick_q;
    assign no_update    = noupd_q;
    assign timeout_err  = terr_q;
    assign row_cathode  = cath_q;
    assign column_anode = anode_q;

    // Next-state and next-output logic for the execution FSM and scan counters.
    always_comb begin
        exec_n    = exec_q;
        gs_n      = gs_q;
        dir_n     = dir_q;
        tick_n    = 1'b0;
        noupd_n   = 1'b0;
        terr_n    = terr_q;
        row_n     = row_q;
        hold_n    = hold_q;
        frame_n   = frame_q;
        tout_n    = '0;
        gend_n    = gend_q;
        start_n   = start_q | (press && (gs_q == GS_INIT));
        pause_n   = pause_q | (pause_in & ~pause_prev_q);
        pop       = 1'b0;
        skip_tick = (gs_q == GS_INIT);
`ifdef SNAKE_PAUSE_EN
        if (gs_q == GS_PAUSE) skip_tick = 1'b1;
`endif
        case (exec_q)
            EX_UPDATE: begin
                exec_n  = EX_CHECK;
                pause_n = pause_in & ~pause_prev_q;
                case (gs_q)
                    GS_INIT: if (start_q) begin
                        gs_n    = GS_RUN;
                        start_n = 1'b0;
                    end
                    GS_RUN: begin
                        if (gend_q) gs_n = GS_STOP;
`ifdef SNAKE_PAUSE_EN
                        else if (pause_q) gs_n = GS_PAUSE;
`endif
                    end
`ifdef SNAKE_PAUSE_EN
                    GS_PAUSE: if (pause_q) gs_n = GS_RUN;
`else
                    GS_PAUSE: gs_n = GS_STOP;
`endif
                    default: ;
                endcase
            end
            // Pop happens on entry to TICK so the new direction is valid
            // during the same clock that logic_tick is high.
            EX_CHECK: begin
                if (skip_tick) begin
                    exec_n = EX_DISPLAY;
                end else begin
                    exec_n  = EX_TICK;
                    tick_n  = 1'b1;
                    noupd_n = (gs_q != GS_RUN);
                    if ((gs_q == GS_RUN) && !q_empty) begin
                        pop   = 1'b1;
                        dir_n = q_head;
                    end
                end
            end
            EX_TICK: begin
                exec_n = EX_WAIT_LOGIC;
                gend_n = 1'b0;
            end
            EX_WAIT_LOGIC: begin
                if (logic_done) begin
                    exec_n = EX_DISPLAY;
                    gend_n = game_end;
                end else if (tout_q == TW'(LOGIC_TIMEOUT - 1)) begin
                    terr_n = 1'b1;
                    gs_n   = GS_STOP;
                    exec_n = EX_DISPLAY;
                end else begin
                    tout_n = tout_q + 1'b1;
                end
            end
            EX_DISPLAY: begin
                if (hold_q == HW'(ROW_HOLD - 1)) begin
                    hold_n = '0;
                    if (row_q == RW'(ROWS - 1)) begin
                        row_n = '0;
                        if (frame_q == FW'(DISPLAY_FRAMES - 1)) begin
                            frame_n = '0;
                            exec_n  = EX_UPDATE;
                        end else begin
                            frame_n = frame_q + 1'b1;
                        end
                    end else begin
                        row_n = row_q + 1'b1;
                    end
                end else begin
                    hold_n = hold_q + 1'b1;
                end
            end
            default: exec_n = EX_UPDATE;
        endcase

        cath_n  = '1;
        anode_n = '0;
        if ((exec_n == EX_DISPLAY) && (hold_n != '0)) begin
            cath_n[row_n] = 1'b0;
            anode_n       = led_flat[row_n*COLS +: COLS];
        end
    end

    // State and registered outputs with synchronous restart.
    always_ff @(posedge clka) begin
        if (restart) begin
            exec_q       <= EX_UPDATE;
            gs_q         <= GS_INIT;
            dir_q        <= DIR_RIGHT;
            tick_q       <= 1'b0;
            noupd_q      <= 1'b0;
            terr_q       <= 1'b0;
            cath_q       <= '1;
            anode_q      <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            frame_q      <= '0;
            tout_q       <= '0;
            gend_q       <= 1'b0;
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            exec_q       <= exec_n;
            gs_q         <= gs_n;
            dir_q        <= dir_n;
            tick_q       <= tick_n;
            noupd_q      <= noupd_n;
            terr_q       <= terr_n;
            cath_q       <= cath_n;
            anode_q      <= anode_n;
            row_q        <= row_n;
            hold_q       <= hold_n;
            frame_q      <= frame_n;
            tout_q       <= tout_n;
            gend_q       <= gend_n;
            start_q      <= start_n;
            pause_q      <= pause_n;
            pause_prev_q <= pause_in;
        end
    end

endmodule

// File: tb/tb_snake_sequencer.sv
// Self-checking bench for snake_sequencer (default parameters).
// Pause behaviour is exercised when SNAKE_PAUSE_EN is defined.
module tb_snake_sequencer;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    localparam logic [1:0] G_INIT = 2'd0, G_RUN = 2'd1, G_STOP = 2'd2, G_PAUSE = 2'd3;
    localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;
    localparam logic [2:0] X_UPDATE = 3'd0, X_CHECK = 3'd1, X_TICK = 3'd2,
                           X_WAIT = 3'd3, X_DISPLAY = 3'd4;
    localparam logic [3:0] B_UP = 4'b0001, B_DOWN = 4'b0010, B_LEFT = 4'b0100, B_RIGHT = 4'b1000;
    localparam logic [ROWS*COLS-1:0] LEDS = 64'hA55A_0FF0_3C81_7E01;

    logic                 clka = 1'b0;
    logic                 restart = 1'b1;
    logic [3:0]           direction_in = 4'b0;
    logic                 logic_done = 1'b0;
    logic                 game_end = 1'b0;
    logic                 pause_in = 1'b0;
    logic [ROWS*COLS-1:0] led_flat = LEDS;
    logic [1:0]           game_state, direction;
    logic [2:0]           exec_state;
    logic                 logic_tick, no_update, timeout_err;
    logic [ROWS-1:0]      row_cathode;
    logic [COLS-1:0]      column_anode;

    always #5 clka = ~clka;

    snake_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .DISPLAY_FRAMES(2), .ROW_HOLD(4),
        .DIR_QDEPTH(2), .LOGIC_TIMEOUT(255)
    ) dut (
        .clka(clka), .restart(restart), .direction_in(direction_in),
        .logic_done(logic_done), .game_end(game_end), .pause_in(pause_in),
        .led_flat(led_flat), .game_state(game_state), .direction(direction),
        .exec_state(exec_state), .logic_tick(logic_tick), .no_update(no_update),
        .timeout_err(timeout_err), .row_cathode(row_cathode), .column_anode(column_anode)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] dir;
        logic       nu;
        logic [1:0] gs;
    } tick_exp_t;
    tick_exp_t sb[$];

    typedef struct {
        logic [3:0] p0, p1, p2;
        logic [1:0] e1, e2;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " game_state"}, game_state, G_INIT);
        chk({tag, " direction"}, direction, D_RIGHT);
        chk({tag, " exec_state"}, exec_state, X_UPDATE);
        chk({tag, " logic_tick"}, logic_tick, 1'b0);
        chk({tag, " no_update"}, no_update, 1'b0);
        chk({tag, " timeout_err"}, timeout_err, 1'b0);
        chk({tag, " row_cathode"}, row_cathode, 8'hFF);
        chk({tag, " column_anode"}, column_anode, 8'h00);
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        @(negedge clka);
        check_reset(tag);
        restart = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        if (b != 4'b0) begin
            direction_in = b;
            repeat (2) @(negedge clka);
            direction_in = 4'b0;
            repeat (2) @(negedge clka);
        end
    endtask

    task automatic pulse_pause();
        pause_in = 1'b1;
        repeat (2) @(negedge clka);
        pause_in = 1'b0;
        repeat (2) @(negedge clka);
    endtask

    task automatic wait_exec(input logic [2:0] x, input string tag);
        int n = 0;
        while (exec_state !== x && n < 300) begin
            @(negedge clka);
            n++;
        end
        chk({tag, " exec reached"}, exec_state, x);
    endtask

    // Wait for a tick request and compare it against the scoreboard head.
    task automatic wait_tick(input string tag);
        tick_exp_t e;
        int n = 0;
        while (logic_tick !== 1'b1 && n < 400) begin
            @(negedge clka);
            n++;
        end
        chk({tag, " tick seen"}, logic_tick, 1'b1);
        if (logic_tick === 1'b1) begin
            chk({tag, " scoreboard has entry"}, sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, " tick direction"}, direction, e.dir);
                chk({tag, " tick no_update"}, no_update, e.nu);
                chk({tag, " tick game_state"}, game_state, e.gs);
            end
        end
    endtask

    task automatic do_tick(input int delay, input logic gend, input string tag);
        wait_tick(tag);
        @(negedge clka);
        chk({tag, " tick one clock"}, logic_tick, 1'b0);
        repeat (delay) @(negedge clka);
        chk({tag, " waiting logic"}, exec_state, X_WAIT);
        logic_done = 1'b1;
        game_end   = gend;
        @(negedge clka);
        logic_done = 1'b0;
        game_end   = 1'b0;
        chk({tag, " display after done"}, exec_state, X_DISPLAY);
    endtask

    task automatic count_ticks(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clka);
            if (logic_tick === 1'b1) cnt++;
        end
    endtask

    // Starts on the first DISPLAY clock; 2 frames x 8 rows x 4 clocks.
    task automatic scan_check();
        int idx, r, h;
        logic [ROWS-1:0] ec;
        logic [COLS-1:0] ea;
        logic [ROWS*COLS-1:0] leds;
        leds = LEDS;
        for (int k = 0; k < 2 * ROWS * 4; k++) begin
            idx = k % (ROWS * 4);
            r   = idx / 4;
            h   = idx % 4;
            ec  = '1;
            ea  = '0;
            if (h != 0) begin
                ec[r] = 1'b0;
                ea    = leds[r*COLS +: COLS];
            end
            chk($sformatf("scan cathode k=%0d", k), row_cathode, ec);
            chk($sformatf("scan anode k=%0d", k), column_anode, ea);
            @(negedge clka);
        end
        chk("scan returns to update", exec_state, X_UPDATE);
        chk("scan idle cathode", row_cathode, 8'hFF);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        vt[0] = '{B_RIGHT, 4'h0,    4'h0,    D_RIGHT, D_RIGHT};
        vt[1] = '{B_LEFT,  B_UP,    B_DOWN,  D_UP,    D_UP};
        vt[2] = '{B_RIGHT, 4'h0,    4'h0,    D_RIGHT, D_RIGHT};
        vt[3] = '{B_UP,    B_LEFT,  B_DOWN,  D_UP,    D_LEFT};
        vt[4] = '{B_LEFT,  4'b0011, B_DOWN,  D_DOWN,  D_DOWN};
        vt[5] = '{B_UP,    B_RIGHT, B_UP,    D_RIGHT, D_UP};

        repeat (3) @(negedge clka);
        check_reset("power-on");
        restart = 1'b0;

        // Start from INIT: RIGHT starts the game (dropped from queue), UP queued.
        press(B_RIGHT);
        press(B_UP);
        chk("init holds before update", game_state, G_INIT);
        wait_exec(X_CHECK, "start");
        chk("run after update", game_state, G_RUN);
        sb.push_back('{D_UP, 1'b0, G_RUN});
        do_tick(1, 1'b0, "first");

        // Turn-filter vectors: presses during one display, checked on the next two ticks.
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{vt[i].e1, 1'b0, G_RUN});
            sb.push_back('{vt[i].e2, 1'b0, G_RUN});
            press(vt[i].p0);
            press(vt[i].p1);
            press(vt[i].p2);
            do_tick(i % 3, 1'b0, $sformatf("vec%0d a", i));
            do_tick(0, 1'b0, $sformatf("vec%0d b", i));
        end

        // Full scan timing of one display phase.
        sb.push_back('{D_UP, 1'b0, G_RUN});
        do_tick(0, 1'b0, "scan");
        scan_check();

        // game_end reported -> STOP at the next update, ticks continue blinking.
        sb.push_back('{D_UP, 1'b0, G_RUN});
        do_tick(2, 1'b1, "gend");
        press(B_LEFT);
        wait_exec(X_CHECK, "gend");
        chk("stop after game_end", game_state, G_STOP);
        sb.push_back('{D_UP, 1'b1, G_STOP});
        do_tick(0, 1'b0, "stop blink");

        do_restart("restart in display");

        // Logic handshake timeout after 255 clocks in WAIT_LOGIC.
        press(B_UP);
        sb.push_back('{D_UP, 1'b0, G_RUN});
        wait_tick("timeout");
        repeat (255) @(negedge clka);
        chk("still waiting at 255", exec_state, X_WAIT);
        chk("no timeout yet", timeout_err, 1'b0);
        @(negedge clka);
        chk("timeout to display", exec_state, X_DISPLAY);
        chk("timeout_err set", timeout_err, 1'b1);
        chk("timeout forces stop", game_state, G_STOP);
        sb.push_back('{D_UP, 1'b1, G_STOP});
        do_tick(0, 1'b0, "after timeout");
        chk("timeout_err sticky", timeout_err, 1'b1);

        do_restart("restart in stop");

        // Restart while a tick is outstanding aborts the handshake.
        press(B_DOWN);
        sb.push_back('{D_DOWN, 1'b0, G_RUN});
        wait_tick("abort");
        repeat (3) @(negedge clka);
        chk("abort in wait", exec_state, X_WAIT);
        do_restart("restart in wait");
        logic_done = 1'b1;
        repeat (2) @(negedge clka);
        logic_done = 1'b0;
        count_ticks(150, cnt);
        chk("no ticks in init", cnt, 0);
        chk("still init", game_state, G_INIT);

        // Pause toggle.
        press(B_UP);
        sb.push_back('{D_UP, 1'b0, G_RUN});
        do_tick(0, 1'b0, "pre-pause");
        pulse_pause();
        wait_exec(X_CHECK, "pause");
`ifdef SNAKE_PAUSE_EN
        chk("paused", game_state, G_PAUSE);
        press(B_LEFT);
        count_ticks(140, cnt);
        chk("no ticks in pause", cnt, 0);
        pulse_pause();
        wait_exec(X_CHECK, "resume");
        chk("resumed", game_state, G_RUN);
        sb.push_back('{D_LEFT, 1'b0, G_RUN});
        do_tick(0, 1'b0, "post-pause");
`else
        chk("pause ignored", game_state, G_RUN);
        sb.push_back('{D_UP, 1'b0, G_RUN});
        do_tick(0, 1'b0, "post-pause");
`endif
        chk("scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
